// File: rtl/keypad_scan_if.sv
// keypad_scan_if
// Bundles the keypad matrix lines and the decoded key outputs of keypad_scan.
//   row       keypad rows, active-low (driven by the keypad / pull-ups)
//   col       column drive, active-low, one bit low at a time
//   onehot    last accepted key, bit = 4*col + row
//   key_valid one-cycle strobe per accepted key (or repeat)
//   key_down  high while the accepted key is held
// Modports: master = the scanner (keypad_scan), slave = keypad side / consumer.
interface keypad_scan_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_down;

  modport master (
    input  row,
    output col,
    output onehot,
    output key_valid,
    output key_down
  );

  modport slave (
    output row,
    input  col,
    input  onehot,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan
// Scans a 4x4 active-low matrix keypad one column at a time, assembles a
// 16-bit snapshot per sweep and debounces it. Only single-key snapshots are
// ever accepted, so onehot carries zero or exactly one set bit.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   kp     keypad_scan_if.master: row in, col/onehot/key_valid/key_down out
// Parameters:
//   SCAN_DIV      clocks each column is driven (>=2)
//   DEBOUNCE_CNT  identical sweeps needed to accept a press or release (>=2)
//   REPEAT_SWEEPS sweeps between auto-repeat strobes (>=1)
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe key_valid every
// REPEAT_SWEEPS sweeps while the accepted key stays held.
module keypad_scan #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE_CNT  = 4,
  parameter int REPEAT_SWEEPS = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  keypad_scan_if.master kp
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(DEBOUNCE_CNT);

  generate
    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_SWEEPS < 1) begin : g_bad_param
      $error("keypad_scan: SCAN_DIV>=2, DEBOUNCE_CNT>=2, REPEAT_SWEEPS>=1 required");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [DIV_W-1:0]  r_div_cnt;
  logic [1:0]        r_col_idx;
  logic [15:0]       r_raw;
  logic              r_sweep_done;
  state_t            r_state;
  logic [STAB_W-1:0] r_stab;
  logic [15:0]       r_cand;
  logic [15:0]       r_onehot;
  logic              r_key_valid;
  logic              r_key_down;

  logic              w_last_dwell;
  logic [15:0]       w_snap;
  logic              w_single;
  logic [STAB_W-1:0] w_stab_inc;
  state_t            w_state_nxt;
  logic [STAB_W-1:0] w_stab_nxt;
  logic [15:0]       w_cand_nxt;
  logic [15:0]       w_onehot_nxt;
  logic              w_accept;
  logic              w_repeat;

  assign w_last_dwell = (r_div_cnt == DIV_LAST);
  // raw is only rewritten at the end of the next col-0 dwell, so it is a
  // stable full-sweep snapshot while sweep_done is high.
  assign w_snap       = r_raw;
  assign w_single     = (w_snap != 16'h0000) && ((w_snap & (w_snap - 16'h0001)) == 16'h0000);
  assign w_stab_inc   = r_stab + STAB_W'(1);

  // ---- scan stage: column drive, row capture, sweep marker ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_col_idx    <= 2'd0;
      r_raw        <= 16'h0000;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= w_last_dwell && (r_col_idx == 2'd3);
      if (w_last_dwell) begin
        r_div_cnt                          <= '0;
        r_col_idx                          <= r_col_idx + 2'd1;
        r_raw[{r_col_idx, 2'b00} +: 4]     <= ~kp.row;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // ---- debounce stage: next-state logic, evaluated once per sweep ----
  always_comb begin
    w_state_nxt  = r_state;
    w_stab_nxt   = r_stab;
    w_cand_nxt   = r_cand;
    w_onehot_nxt = r_onehot;
    w_accept     = 1'b0;
    if (r_sweep_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt  = w_snap;
            w_stab_nxt  = STAB_W'(1);
            w_state_nxt = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (w_snap == r_cand) begin
            w_stab_nxt = w_stab_inc;
            if (w_stab_inc == STAB_DONE) begin
              w_state_nxt  = S_PRESSED;
              w_onehot_nxt = r_cand;
              w_accept     = 1'b1;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_PRESSED: begin
          // Any key pattern other than all-released keeps us here: rollover
          // is ignored until the keypad is fully released.
          if (w_snap == 16'h0000) begin
            w_stab_nxt  = STAB_W'(1);
            w_state_nxt = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_snap == 16'h0000) begin
            w_stab_nxt = w_stab_inc;
            if (w_stab_inc == STAB_DONE) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_PRESSED;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SWEEPS + 1);
  localparam logic [REP_W-1:0] REP_DONE = REP_W'(REPEAT_SWEEPS);

  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_inc;
  logic [REP_W-1:0] w_rep_nxt;

  assign w_rep_inc = r_rep + REP_W'(1);

  // Counter only advances on PRESSED sweeps that still show the accepted key;
  // every other sweep clears it, which also covers entry into PRESSED.
  always_comb begin
    w_rep_nxt = r_rep;
    w_repeat  = 1'b0;
    if (r_sweep_done) begin
      if (r_state == S_PRESSED && w_snap == r_cand) begin
        if (w_rep_inc == REP_DONE) begin
          w_repeat  = 1'b1;
          w_rep_nxt = '0;
        end else begin
          w_rep_nxt = w_rep_inc;
        end
      end else begin
        w_rep_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_rep_nxt;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // ---- output stage: state and registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stab      <= '0;
      r_cand      <= 16'h0000;
      r_onehot    <= 16'h0000;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stab      <= w_stab_nxt;
      r_cand      <= w_cand_nxt;
      r_onehot    <= w_onehot_nxt;
      r_key_valid <= w_accept | w_repeat;
      r_key_down  <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE);
    end
  end

  assign kp.col       = ~(4'b0001 << r_col_idx);
  assign kp.onehot    = r_onehot;
  assign kp.key_valid = r_key_valid;
  assign kp.key_down  = r_key_down;

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad and debounces it. Produces a held 16-bit one-hot key code plus a one-cycle `key_valid` strobe per accepted press. Sits directly upstream of the one-hot→BCD digit encoder in the display path: `onehot` feeds that encoder's one-hot input unchanged. Multi-key presses and bounce are filtered here, so the encoder only ever sees zero or exactly one bit set.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column is driven (dwell); ≥2.
- `DEBOUNCE_CNT`, 4: consecutive identical sweeps required to accept a press or a release; ≥2.
- `REPEAT_SWEEPS`, 64: sweeps between auto-repeat strobes; used only with the macro; ≥1.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `row`  in  4  keypad rows, active-low (external pull-ups).
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `onehot`  out  16  last accepted key; bit index = 4*col_index + row_index.
- `key_valid`  out  1  one-cycle strobe when `onehot` takes a new accepted key (or on a repeat).
- `key_down`  out  1  high while the accepted key is considered held.

## Operation
- Scan: `div_cnt` counts 0..SCAN_DIV-1. `col_idx` counts 0..3 and advances when `div_cnt` wraps; col 3 wraps to col 0.
- `col = ~(4'b1 << col_idx)`.
- On the last dwell cycle (`div_cnt == SCAN_DIV-1`), capture `~row` into `raw[4*col_idx +: 4]`. The preceding cycles of the dwell are settling time.
- After the col-3 capture, assert internal `sweep_done` for one cycle. At that point `snap` = the complete 16-bit `raw`.
- `single` = `snap` has exactly one bit set.
- FSM advances only on `sweep_done`:
  - IDLE: if `single`, set `cand <= snap`, `stab <= 1`, go to DEBOUNCE. Otherwise stay.
  - DEBOUNCE: if `snap == cand`, increment `stab`. When it reaches DEBOUNCE_CNT: go to PRESSED, `onehot <= cand`, pulse `key_valid`. If `snap != cand`, return to IDLE (no output change).
  - PRESSED: if `snap == 0`, set `stab <= 1`, go to RELEASE. If any key is down (same, added, or changed), stay; no new strobe. Rollover is ignored until a full release.
  - RELEASE: if `snap == 0`, increment `stab`. When it reaches DEBOUNCE_CNT, go to IDLE. If `snap != 0`, return to PRESSED (release bounce) with no strobe.
- `key_down` = 1 in PRESSED and RELEASE.
- `onehot` holds its value through release and IDLE. It changes only on acceptance.
- A 2+ key `snap` is never accepted.

## Timing
- Reset values: `col = 4'b1110`, `onehot = 16'h0000`, `key_valid = 0`, `key_down = 0`, state IDLE, `div_cnt`/`col_idx`/`stab`/`raw` = 0.
- Sweep period = 4*SCAN_DIV cycles. `sweep_done` fires once per sweep, at the cycle after the col-3 capture.
- Press latency: `key_valid` and the new `onehot` appear in the same cycle, one cycle after the DEBOUNCE_CNT-th consecutive matching `sweep_done`. First detection counts as sweep 1.
- `key_down` rises with `key_valid`. It falls one cycle after the DEBOUNCE_CNT-th consecutive all-zero sweep.
- `key_valid` is never high for two consecutive cycles.
- Reset mid-scan or mid-debounce returns everything to reset values on the next edge. There is no partial strobe.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In PRESSED, a sweep counter runs.
  - Every REPEAT_SWEEPS sweeps with `snap == cand`, re-pulse `key_valid`; `onehot` is unchanged.
  - The counter clears on entering PRESSED, on any sweep with `snap != cand`, and on each repeat.
- Undefined: exactly one `key_valid` per press. The repeat counter logic is absent.

## Test plan
Common settings: SCAN_DIV=4, DEBOUNCE_CNT=3 (sweep = 16 cycles).
- Reset: hold `rst_n` low 5 cycles → `col = 4'b1110`, `onehot = 0`, `key_valid = 0`; `col` then walks 1110→1101→1011→0111 every 4 cycles.
- Clean press of col 1 / row 2 → `onehot = 16'h0040` with a single `key_valid` after the 3rd sweep. `key_down` is high until 3 empty sweeps after release; `onehot` stays `16'h0040` afterwards.
- Bounce: key present 1 sweep, absent 1 sweep, present 3 sweeps → exactly one `key_valid`, issued at the end of the last of the 3 consecutive sweeps.
- Two keys (bits 3 and 8) held 10 sweeps → no `key_valid`, `onehot` unchanged. Releasing bit 8 → accept `16'h0008` after 3 sweeps.
- Reset asserted during DEBOUNCE (2nd sweep) → no strobe. Key still held after reset → accepted 3 sweeps later.
- With `KEYPAD_AUTOREPEAT_EN` and REPEAT_SWEEPS=2, key held 9 sweeps after acceptance → 4 extra `key_valid` pulses, 32 cycles apart.
